hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It is the producer side of the per-stage `stall`/`bubble` pair that every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register consume. It detects the following hazards and emits the freeze/flush pattern for each:
- load-use
- branch/jump redirect
- multicycle MDU (mult/div) occupancy
- data-memory wait

It also keeps an MDU busy timer and a stall-cycle performance counter.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/hazard_ctrl_if.sv | 47 ++++
 rtl/hazard_ctrl_mdu_busy_timer.sv | 75 +++++++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the pipeline hazard controller.
//   - REG_IDX_W           : register-index width
//   - mdu_state_t         : MDU busy-timer FSM states
//   - MDU_LATENCY_DEFAULT : default mult/div occupancy in cycles
//   - stage_ctrl_t        : per-stage stall/bubble control bundle
//   - src_hit()           : true when a used, nonzero source matches a destination
package mips_pkg;

  localparam int REG_IDX_W           = 5;
  localparam int MDU_LATENCY_DEFAULT = 32;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } mdu_state_t;

  typedef struct packed {
    logic stall;
    logic bubble;
  } stage_ctrl_t;

  // $0 is hard-wired, so a zero source index can never depend on anything.
  function automatic logic src_hit(input logic                 use_src,
                                   input logic [REG_IDX_W-1:0] src,
                                   input logic [REG_IDX_W-1:0] dst);
    return use_src && (src != {REG_IDX_W{1'b0}}) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundles the pipeline-side hazard inputs and the per-stage
// freeze/flush outputs of the hazard controller.
//   master : pipeline side (drives ID/EX/MEM status, receives stall/bubble)
//   slave  : controller side (receives status, drives stall/bubble/busy/count)
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  import mips_pkg::*;

  logic [REG_IDX_W-1:0] id_rs;
  logic [REG_IDX_W-1:0] id_rt;
  logic                 id_use_rs;
  logic                 id_use_rt;
  logic                 id_mdu_read;
  logic                 ex_mem_read;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_branch_taken;
  logic                 ex_mdu_start;
  logic                 mem_mem_wait;

  logic                 pc_stall;
  logic                 ifid_stall;
  logic                 ifid_bubble;
  logic                 idex_stall;
  logic                 idex_bubble;
  logic                 exmem_stall;
  logic                 exmem_bubble;
  logic                 memwb_stall;
  logic                 memwb_bubble;
  logic                 mdu_busy;
  logic [CNT_W-1:0]     stall_count;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_mdu_read,
           ex_mem_read, ex_rd, ex_branch_taken, ex_mdu_start, mem_mem_wait,
    input  pc_stall, ifid_stall, ifid_bubble, idex_stall, idex_bubble,
           exmem_stall, exmem_bubble, memwb_stall, memwb_bubble,
           mdu_busy, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_mdu_read,
           ex_mem_read, ex_rd, ex_branch_taken, ex_mdu_start, mem_mem_wait,
    output pc_stall, ifid_stall, ifid_bubble, idex_stall, idex_bubble,
           exmem_stall, exmem_bubble, memwb_stall, memwb_bubble,
           mdu_busy, stall_count
  );

endinterface

// File: rtl/hazard_ctrl_mdu_busy_timer.sv
// mdu_busy_timer: tracks mult/div occupancy with an 8-bit down-counter.
//   clk   in  pipeline clock
//   nrst  in  asynchronous active-low reset
//   start in  EX issues mult/div this cycle
//   busy  out counter nonzero (MDU occupied)
module mdu_busy_timer
  import mips_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic nrst,
  input  logic start,
  output logic busy
);

  localparam logic [7:0] LOAD_VAL = 8'(MDU_LATENCY);

  mdu_state_t state;
  mdu_state_t state_next;
  logic [7:0] cnt;
  logic [7:0] cnt_next;

  // State and counter registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= RUN;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; the counter runs regardless of pipeline stalls.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RUN: begin
        if (start) begin
          state_next = MDU_WAIT;
          cnt_next   = LOAD_VAL;
        end else begin
          state_next = RUN;
          cnt_next   = 8'd0;
        end
      end
      MDU_WAIT: begin
        // Last busy cycle: a start here chains straight into a new wait.
        // cnt==0 cannot occur in MDU_WAIT; it is folded in to recover cleanly.
        if (cnt <= 8'd1) begin
          if (start) begin
            state_next = MDU_WAIT;
            cnt_next   = LOAD_VAL;
          end else begin
            state_next = RUN;
            cnt_next   = 8'd0;
          end
        end else begin
          // A start earlier in the wait is a structural stall, not a reload.
          state_next = MDU_WAIT;
          cnt_next   = cnt - 8'd1;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = 8'd0;
      end
    endcase
  end

  assign busy = (cnt != 8'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core.
// Produces the PC stall and per-stage stall/bubble pairs for IF/ID, ID/EX,
// EX/MEM and MEM/WB from load-use, redirect, MDU and memory-wait hazards,
// and counts PC-stall cycles.
//   i_ID_*   : ID-stage source usage      i_EX_* : EX-stage load/dest/branch/MDU
//   i_MEM_memWait : data memory not done   o_*_stall / o_*_bubble : controls
//   o_mduBusy : MDU occupied               o_stallCount : PC-stall cycles
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MDU_LATENCY = MDU_LATENCY_DEFAULT,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [REG_IDX_W-1:0] i_ID_rs,
  input  logic [REG_IDX_W-1:0] i_ID_rt,
  input  logic                 i_ID_useRs,
  input  logic                 i_ID_useRt,
  input  logic                 i_ID_mduRead,
  input  logic                 i_EX_memRead,
  input  logic [REG_IDX_W-1:0] i_EX_rd,
  input  logic                 i_EX_branchTaken,
  input  logic                 i_EX_mduStart,
  input  logic                 i_MEM_memWait,
  output logic                 o_PC_stall,
  output logic                 o_IFID_stall,
  output logic                 o_IFID_bubble,
  output logic                 o_IDEX_stall,
  output logic                 o_IDEX_bubble,
  output logic                 o_EXMEM_stall,
  output logic                 o_EXMEM_bubble,
  output logic                 o_MEMWB_stall,
  output logic                 o_MEMWB_bubble,
  output logic                 o_mduBusy,
  output logic [CNT_W-1:0]     o_stallCount
);

  logic        mdu_busy;
  logic        load_use;
  logic        mdu_raw;
  logic        mdu_struct;
  logic        pc_stall;
  stage_ctrl_t ifid;
  stage_ctrl_t idex;
  stage_ctrl_t exmem;
  stage_ctrl_t memwb;
  logic [CNT_W-1:0] stall_cnt;

  mdu_busy_timer #(
    .MDU_LATENCY (MDU_LATENCY)
  ) u_mdu_timer (
    .clk   (clk),
    .nrst  (nrst),
    .start (i_EX_mduStart),
    .busy  (mdu_busy)
  );

  assign load_use = i_EX_memRead && (i_EX_rd != {REG_IDX_W{1'b0}}) &&
                    (src_hit(i_ID_useRs, i_ID_rs, i_EX_rd) ||
                     src_hit(i_ID_useRt, i_ID_rt, i_EX_rd));
  assign mdu_raw    = i_ID_mduRead && mdu_busy;
  assign mdu_struct = i_EX_mduStart && mdu_busy;

  // Priority decoder: memory wait > redirect > MDU structural > data hazards.
  always_comb begin
    pc_stall = 1'b0;
    ifid     = '{stall: 1'b0, bubble: 1'b0};
    idex     = '{stall: 1'b0, bubble: 1'b0};
    exmem    = '{stall: 1'b0, bubble: 1'b0};
    memwb    = '{stall: 1'b0, bubble: 1'b0};
    if (i_MEM_memWait) begin
      pc_stall    = 1'b1;
      ifid.stall  = 1'b1;
      idex.stall  = 1'b1;
      exmem.stall = 1'b1;
      memwb.stall = 1'b1;
    end else if (i_EX_branchTaken) begin
      // The ID instruction is squashed, so its hazards no longer matter.
      ifid.bubble = 1'b1;
      idex.bubble = 1'b1;
    end else if (mdu_struct) begin
      pc_stall     = 1'b1;
      ifid.stall   = 1'b1;
      idex.stall   = 1'b1;
      exmem.bubble = 1'b1;
    end else if (load_use || mdu_raw) begin
      pc_stall    = 1'b1;
      ifid.stall  = 1'b1;
      idex.bubble = 1'b1;
    end else begin
      pc_stall = 1'b0;
    end
  end

  // Controls are held inactive for as long as reset is asserted.
  assign o_PC_stall     = pc_stall     & nrst;
  assign o_IFID_stall   = ifid.stall   & nrst;
  assign o_IFID_bubble  = ifid.bubble  & nrst;
  assign o_IDEX_stall   = idex.stall   & nrst;
  assign o_IDEX_bubble  = idex.bubble  & nrst;
  assign o_EXMEM_stall  = exmem.stall  & nrst;
  assign o_EXMEM_bubble = exmem.bubble & nrst;
  assign o_MEMWB_stall  = memwb.stall  & nrst;
  assign o_MEMWB_bubble = memwb.bubble & nrst;
  assign o_mduBusy      = mdu_busy;

  // Stall-cycle performance counter, wraps naturally.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (o_PC_stall) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  assign o_stallCount = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. Stimulus pushes the
// reference model's expectation per cycle; a monitor pops and compares.
module tb_hazard_ctrl;
  import mips_pkg::*;

  localparam int LAT = 4;
  localparam int CW  = 4;

  typedef struct packed {
    logic [8:0]    haz;   // pc, ifid s/b, idex s/b, exmem s/b, memwb s/b
    logic          busy;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();

  hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .i_ID_rs          (hif.id_rs),
    .i_ID_rt          (hif.id_rt),
    .i_ID_useRs       (hif.id_use_rs),
    .i_ID_useRt       (hif.id_use_rt),
    .i_ID_mduRead     (hif.id_mdu_read),
    .i_EX_memRead     (hif.ex_mem_read),
    .i_EX_rd          (hif.ex_rd),
    .i_EX_branchTaken (hif.ex_branch_taken),
    .i_EX_mduStart    (hif.ex_mdu_start),
    .i_MEM_memWait    (hif.mem_mem_wait),
    .o_PC_stall       (hif.pc_stall),
    .o_IFID_stall     (hif.ifid_stall),
    .o_IFID_bubble    (hif.ifid_bubble),
    .o_IDEX_stall     (hif.idex_stall),
    .o_IDEX_bubble    (hif.idex_bubble),
    .o_EXMEM_stall    (hif.exmem_stall),
    .o_EXMEM_bubble   (hif.exmem_bubble),
    .o_MEMWB_stall    (hif.memwb_stall),
    .o_MEMWB_bubble   (hif.memwb_bubble),
    .o_mduBusy        (hif.mdu_busy),
    .o_stallCount     (hif.stall_count)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model state: cycle index, last busy cycle, stall count.
  int cyc      = 0;
  int busy_end = -1;
  int m_cnt    = 0;

  task automatic set_idle();
    hif.id_rs = 5'd0; hif.id_rt = 5'd0;
    hif.id_use_rs = 1'b0; hif.id_use_rt = 1'b0; hif.id_mdu_read = 1'b0;
    hif.ex_mem_read = 1'b0; hif.ex_rd = 5'd0; hif.ex_branch_taken = 1'b0;
    hif.ex_mdu_start = 1'b0; hif.mem_mem_wait = 1'b0;
  endtask

  function automatic logic [8:0] ref_haz(input logic busy);
    logic lu;
    lu = hif.ex_mem_read && (hif.ex_rd != 5'd0) &&
         ((hif.id_use_rs && hif.id_rs == hif.ex_rd) ||
          (hif.id_use_rt && hif.id_rt == hif.ex_rd));
    if (hif.mem_mem_wait)                    return 9'b1_10_10_10_10;
    else if (hif.ex_branch_taken)            return 9'b0_01_01_00_00;
    else if (hif.ex_mdu_start && busy)       return 9'b1_10_10_01_00;
    else if (lu || (hif.id_mdu_read && busy)) return 9'b1_10_01_00_00;
    else                                     return 9'b0_00_00_00_00;
  endfunction

  // Called at posedge+1 with inputs applied: predict this cycle, advance model.
  task automatic commit();
    exp_t e;
    logic busy;
    if (!nrst) begin
      e        = exp_t'(0);
      busy_end = -1;
      m_cnt    = 0;
    end else begin
      busy   = (cyc <= busy_end);
      e.haz  = ref_haz(busy);
      e.busy = busy;
      e.cnt  = CW'(m_cnt);
      if (e.haz[8]) m_cnt = (m_cnt + 1) % (1 << CW);
      if (hif.ex_mdu_start && (!busy || cyc == busy_end)) busy_end = cyc + LAT;
    end
    exp_q.push_back(e);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare mid-cycle, away from the active edge.
  initial begin
    exp_t e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {hif.pc_stall, hif.ifid_stall, hif.ifid_bubble,
               hif.idex_stall, hif.idex_bubble, hif.exmem_stall,
               hif.exmem_bubble, hif.memwb_stall, hif.memwb_bubble};
        checks++;
        if (got === e.haz) passes++;
        else $display("FAIL hazard_vec t=%0t: got %b expected %b", $time, got, e.haz);
        checks++;
        if (hif.mdu_busy === e.busy) passes++;
        else $display("FAIL mdu_busy t=%0t: got %b expected %b", $time, hif.mdu_busy, e.busy);
        checks++;
        if (hif.stall_count === e.cnt) passes++;
        else $display("FAIL stall_count t=%0t: got %0d expected %0d", $time, hif.stall_count, e.cnt);
      end
    end
  end

  initial begin
    set_idle();
    nrst = 1'b0;
    @(posedge clk);
    #1;
    hif.mem_mem_wait = 1'b1;   // outputs must stay low while in reset
    commit();
    commit();
    nrst = 1'b1;
    set_idle();
    commit();

    // Load-use on rs, then rd=0, rt match, unused source.
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd5; hif.id_rs = 5'd5; hif.id_use_rs = 1'b1;
    commit();
    hif.ex_rd = 5'd0; hif.id_rs = 5'd0;
    commit();
    hif.id_rs = 5'd5;
    commit();
    hif.ex_rd = 5'd7; hif.id_rt = 5'd7; hif.id_use_rt = 1'b1; hif.id_use_rs = 1'b0;
    commit();
    hif.id_use_rt = 1'b0; hif.id_rs = 5'd7;
    commit();

    // Redirect overrides load-use.
    hif.id_use_rs = 1'b1; hif.ex_branch_taken = 1'b1;
    commit();
    set_idle();

    // MDU start then mfhi waiting in ID.
    hif.ex_mdu_start = 1'b1;
    commit();
    hif.ex_mdu_start = 1'b0; hif.id_mdu_read = 1'b1;
    repeat (6) commit();
    set_idle();

    // Repeated start while busy, including a start in the last busy cycle.
    hif.ex_mdu_start = 1'b1;
    commit();
    hif.ex_mdu_start = 1'b0;
    commit();
    hif.ex_mdu_start = 1'b1;
    repeat (6) commit();
    set_idle();
    repeat (LAT + 2) commit();

    // Memory wait during an MDU wait.
    hif.ex_mdu_start = 1'b1;
    commit();
    hif.ex_mdu_start = 1'b0; hif.mem_mem_wait = 1'b1;
    repeat (3) commit();
    set_idle();
    repeat (3) commit();

    // Reset with cnt=2 in the middle of an MDU wait.
    hif.ex_mdu_start = 1'b1;
    commit();
    set_idle();
    commit();
    commit();
    hif.id_mdu_read = 1'b1; hif.mem_mem_wait = 1'b1;
    nrst = 1'b0;
    #1;
    commit();
    commit();
    nrst = 1'b1;
    set_idle();
    hif.id_mdu_read = 1'b1;
    repeat (3) commit();

    // Randomized traffic with occasional resets; small register range for hits.
    for (int i = 0; i < 600; i++) begin
      hif.id_rs           = 5'($urandom_range(0, 3));
      hif.id_rt           = 5'($urandom_range(0, 3));
      hif.id_use_rs       = 1'($urandom_range(0, 1));
      hif.id_use_rt       = 1'($urandom_range(0, 1));
      hif.id_mdu_read     = ($urandom_range(0, 2) == 0);
      hif.ex_mem_read     = ($urandom_range(0, 2) == 0);
      hif.ex_rd           = 5'($urandom_range(0, 3));
      hif.ex_branch_taken = ($urandom_range(0, 7) == 0);
      hif.ex_mdu_start    = ($urandom_range(0, 5) == 0);
      hif.mem_mem_wait    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 149) == 0) begin
        nrst = 1'b0;
        #1;
        commit();
        nrst = 1'b1;
      end else begin
        commit();
      end
    end
    set_idle();

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    #2;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
